// File: rtl/f5_sweep.sv
// f5_sweep: clocked stimulus sequencer for a two-input gate (default: f5_nand,
// s = ~a | b). On start it walks {a,b} through 00,01,10,11, holds each vector
// SETTLE cycles, samples the gate output once per vector, builds the measured
// truth table and compares it with EXPECT.
// Optional feature: define F5_SWEEP_RESTART_EN to let start abort and restart
// a running sweep; without it, start is only honoured in IDLE.
module f5_sweep #(
    parameter int unsigned SETTLE = 1,
    parameter logic [3:0]  EXPECT = 4'b1011
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       s_in,
    output logic       x_out,
    output logic       y_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] table_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Last DRIVE count of a vector; the following cycle is the sample cycle.
    localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

    state_t     state;
    logic [1:0] idx;
    logic [7:0] cnt;
    logic [1:0] idx_nxt;

    assign idx_nxt = idx + 2'd1;

    // Status flags decoded straight from the state register, no input paths.
    assign busy = (state == DRIVE) || (state == SAMPLE);
    assign done = (state == DONE);

    // Sweep sequencer: vector index, settle counter, gate drive and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 2'd0;
            cnt       <= 8'd0;
            x_out     <= 1'b0;
            y_out     <= 1'b0;
            pass      <= 1'b0;
            table_out <= 4'b0000;
        end else begin
`ifdef F5_SWEEP_RESTART_EN
            // A new request mid-sweep throws the partial result away and
            // starts over from vector 00, exactly like an IDLE accept.
            if (start && ((state == DRIVE) || (state == SAMPLE))) begin
                state     <= DRIVE;
                idx       <= 2'd0;
                cnt       <= 8'd0;
                x_out     <= 1'b0;
                y_out     <= 1'b0;
                pass      <= 1'b0;
                table_out <= 4'b0000;
            end else
`endif
            begin
                case (state)
                    IDLE: begin
                        x_out <= 1'b0;
                        y_out <= 1'b0;
                        if (start) begin
                            state     <= DRIVE;
                            idx       <= 2'd0;
                            cnt       <= 8'd0;
                            pass      <= 1'b0;
                            table_out <= 4'b0000;
                        end
                    end
                    DRIVE: begin
                        x_out <= idx[1];
                        y_out <= idx[0];
                        cnt   <= cnt + 8'd1;
                        if (cnt == CNT_LAST) begin
                            state <= SAMPLE;
                        end
                    end
                    SAMPLE: begin
                        table_out[idx] <= s_in;
                        if (idx == 2'd3) begin
                            // Last entry is still in flight, so splice s_in in directly.
                            pass  <= ({s_in, table_out[2:0]} == EXPECT);
                            x_out <= 1'b0;
                            y_out <= 1'b0;
                            state <= DONE;
                        end else begin
                            idx   <= idx_nxt;
                            cnt   <= 8'd0;
                            x_out <= idx_nxt[1];
                            y_out <= idx_nxt[0];
                            state <= DRIVE;
                        end
                    end
                    default: begin
                        // DONE lasts one cycle; start here is ignored.
                        x_out <= 1'b0;
                        y_out <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_f5_sweep.sv
// Testbench for f5_sweep: two instances (SETTLE=1 and SETTLE=3) in front of a
// behavioural gate model. Stimulus pushes expected sweep records into per-DUT
// queues; a negedge monitor checks every cycle and pops a record on done.
module tb_f5_sweep;

    localparam logic [3:0] GOOD = 4'b1011;   // f5 truth table, bit {a,b}

    typedef struct {
        int         e;       // cycle number of the accepting edge
        int         s;       // settle cycles of that DUT
        logic [3:0] tbl;     // expected measured table
        logic       pss;     // expected pass
        int         abort;   // cycle from which the sweep no longer exists, -1 = never
    } rec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] start_v = 2'b00;
    logic [1:0] s_v;
    logic [1:0] x_v, y_v, busy_v, done_v, pass_v;
    logic [3:0] tbl0, tbl1;

    int   cyc = 0;
    logic rst_q = 1'b0;
    int   mode [2];          // 0 real gate, 1 stuck 0, 2 stuck 1, 3 real gate with settle glitch
    int   hc [2];            // cycles the current {busy,x,y} has been visible
    logic [2:0] prev [2];
    logic [3:0] last_tbl [2];
    logic       last_pass [2];

    rec_t sb0[$];
    rec_t sb1[$];

    int n_checks = 0;
    int n_err = 0;

    f5_sweep #(.SETTLE(1), .EXPECT(4'b1011)) u_dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .s_in(s_v[0]),
        .x_out(x_v[0]), .y_out(y_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .table_out(tbl0)
    );

    f5_sweep #(.SETTLE(3), .EXPECT(4'b1011)) u_dut1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .s_in(s_v[1]),
        .x_out(x_v[1]), .y_out(y_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .table_out(tbl1)
    );

    always #5 clk = ~clk;

    // Cycle counter and registered view of reset, both updated at the active edge.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    // Gate model in front of each DUT.
    always_comb begin
        s_v = 2'b00;
        for (int d = 0; d < 2; d++) begin
            case (mode[d])
                1:       s_v[d] = 1'b0;
                2:       s_v[d] = 1'b1;
                3:       s_v[d] = (~x_v[d] | y_v[d]) ^ (busy_v[d] && (hc[d] < 2));
                default: s_v[d] = ~x_v[d] | y_v[d];
            endcase
        end
    end

    // Track how long each applied vector has been stable.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if ({busy_v[d], x_v[d], y_v[d]} != prev[d]) hc[d] = 0;
            else hc[d] = hc[d] + 1;
            prev[d] = {busy_v[d], x_v[d], y_v[d]};
        end
    end

    function automatic int settle_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [3:0] get_tbl(input int d);
        return (d == 0) ? tbl0 : tbl1;
    endfunction

    function automatic int q_size(input int d);
        return (d == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic rec_t q_head(input int d);
        return (d == 0) ? sb0[0] : sb1[0];
    endfunction

    task automatic q_pop(input int d);
        if (d == 0) void'(sb0.pop_front());
        else void'(sb1.pop_front());
    endtask

    task automatic q_abort_all(input int d, input int r);
        if (d == 0) begin
            foreach (sb0[i]) sb0[i].abort = r;
        end else begin
            foreach (sb1[i]) sb1[i].abort = r;
        end
    endtask

    // Truth table the gate model should produce under a given mode.
    function automatic logic [3:0] exp_table(input int m);
        logic [3:0] t;
        logic [1:0] vv;
        t = 4'b0000;
        for (int v = 0; v < 4; v++) begin
            vv = v[1:0];
            case (m)
                1:       t[v] = 1'b0;
                2:       t[v] = 1'b1;
                default: t[v] = ~vv[1] | vv[0];
            endcase
        end
        return t;
    endfunction

    task automatic push_sweep(input int d, input int e, input int m);
        rec_t r;
        r.e     = e;
        r.s     = settle_of(d);
        r.tbl   = exp_table(m);
        r.pss   = (exp_table(m) == GOOD);
        r.abort = -1;
        if (d == 0) sb0.push_back(r);
        else sb1.push_back(r);
    endtask

    task automatic chk(input string name, input int d, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d cyc=%0d actual=%b required=%b", name, d, cyc, act, exp);
        end
    endtask

    // Monitor: per-cycle comparison of each DUT against the head expected sweep.
    always @(negedge clk) begin
        rec_t h;
        bit   active;
        int   per, dur, k, v;
        logic [1:0] vb;
        if (cyc >= 1) begin
            for (int d = 0; d < 2; d++) begin
                if (rst_q) begin
                    last_tbl[d]  = 4'b0000;
                    last_pass[d] = 1'b0;
                end
                while (q_size(d) > 0) begin
                    h = q_head(d);
                    if (h.abort >= 0 && h.abort <= cyc) q_pop(d);
                    else break;
                end
                active = 1'b0;
                if (q_size(d) > 0) begin
                    h = q_head(d);
                    if (h.e <= cyc) active = 1'b1;
                end
                if (active) begin
                    per = h.s + 1;
                    dur = 4 * per;
                    k   = cyc - h.e;
                    if (k < dur) begin
                        v  = k / per;
                        vb = v[1:0];
                        chk("busy_run", d, 4'(busy_v[d]), 4'b0001);
                        chk("done_run", d, 4'(done_v[d]), 4'b0000);
                        chk("x_vec", d, 4'(x_v[d]), 4'(vb[1]));
                        chk("y_vec", d, 4'(y_v[d]), 4'(vb[0]));
                    end else begin
                        chk("done_pulse", d, 4'(done_v[d]), 4'b0001);
                        chk("busy_done", d, 4'(busy_v[d]), 4'b0000);
                        chk("xy_done", d, {2'b00, x_v[d], y_v[d]}, 4'b0000);
                        chk("table", d, get_tbl(d), h.tbl);
                        chk("pass", d, 4'(pass_v[d]), 4'(h.pss));
                        last_tbl[d]  = h.tbl;
                        last_pass[d] = h.pss;
                        q_pop(d);
                    end
                end else begin
                    chk("busy_idle", d, 4'(busy_v[d]), 4'b0000);
                    chk("done_idle", d, 4'(done_v[d]), 4'b0000);
                    chk("xy_idle", d, {2'b00, x_v[d], y_v[d]}, 4'b0000);
                    chk("table_hold", d, get_tbl(d), last_tbl[d]);
                    chk("pass_hold", d, 4'(pass_v[d]), 4'(last_pass[d]));
                end
            end
        end
    end

    // One-cycle start pulse; returns the cycle number of the accepting edge.
    task automatic pulse_start(input int d, output int e);
        @(posedge clk);
        #1;
        start_v[d] = 1'b1;
        @(posedge clk);
        #1;
        start_v[d] = 1'b0;
        e = cyc;
    endtask

    // Full sweep; returns one ns after the edge that enters DONE.
    task automatic run_sweep(input int d, input int m);
        int e;
        mode[d] = m;
        pulse_start(d, e);
        push_sweep(d, e, m);
        repeat (4 * (settle_of(d) + 1)) @(posedge clk);
        #1;
    endtask

    initial begin
        int e, e2, d, m, gap;
        mode[0] = 0;
        mode[1] = 0;
        hc[0] = 0;
        hc[1] = 0;
        prev[0] = 3'b000;
        prev[1] = 3'b000;
        last_tbl[0] = 4'b0000;
        last_tbl[1] = 4'b0000;
        last_pass[0] = 1'b0;
        last_pass[1] = 1'b0;

        // Reset held two cycles, then ten quiet cycles.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Real gate, stuck-at-0, stuck-at-1 on both settle settings.
        run_sweep(0, 0);
        run_sweep(0, 1);
        run_sweep(0, 2);
        run_sweep(1, 0);
        run_sweep(1, 3);
        run_sweep(1, 1);

        // Back-to-back sweeps at the earliest legal accept.
        run_sweep(0, 0);
        run_sweep(0, 0);

        // Reset while vector 10 is applied aborts the sweep silently.
        mode[0] = 0;
        pulse_start(0, e);
        push_sweep(0, e, 0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        q_abort_all(0, cyc + 1);
        q_abort_all(1, cyc + 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_sweep(0, 0);

        // Start re-pulsed during cycle 5 of a sweep.
        mode[0] = 0;
        pulse_start(0, e);
        push_sweep(0, e, 0);
        repeat (4) @(posedge clk);
        #1;
        pulse_start(0, e2);
`ifdef F5_SWEEP_RESTART_EN
        q_abort_all(0, e2);
        push_sweep(0, e2, 0);
        repeat (8) @(posedge clk);
        #1;
`else
        repeat (2) @(posedge clk);
        #1;
`endif
        repeat (3) @(posedge clk);
        #1;

        // Randomised sweeps with random idle gaps.
        for (int i = 0; i < 14; i++) begin
            d   = int'($urandom_range(1, 0));
            m   = int'($urandom_range((d == 1) ? 3 : 2, 0));
            gap = int'($urandom_range(3, 0));
            repeat (gap) @(posedge clk);
            #1;
            run_sweep(d, m);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("sb0_drained", 0, 4'(q_size(0)), 4'b0000);
        chk("sb1_drained", 1, 4'(q_size(1)), 4'b0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/f5_sweep.md
# f5_sweep

Self-checking stimulus sequencer placed directly upstream of the `f5_nand` gate (s = ~(a & ~b), i.e. ~a | b). On a start request it drives the gate's `a`/`b` inputs through all four input combinations, samples the gate output `s` after a configurable settle time, assembles the measured truth table and compares it against an expected pattern. It replaces the hand-written `#1` stimulus of the unit test with a synthesizable, clocked sweep that later guide exercises can reuse in front of other two-input gates.

## Interface

- `SETTLE`, 1: cycles each input vector is held before `s` is sampled; legal range 1..255.
- `EXPECT`, 4'b1011: expected truth table, bit index = {a,b}; default matches f5 (00→1, 01→1, 10→0, 11→1).

- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  sweep request; sampled only in IDLE.
- `s_in`  input  1  output `s` of the gate under test.
- `x_out`  output  1  drives gate input `a`.
- `y_out`  output  1  drives gate input `b`.
- `busy`  output  1  high while a sweep is running (DRIVE/SAMPLE).
- `done`  output  1  one-cycle pulse when a sweep completes.
- `pass`  output  1  1 when last completed sweep matched `EXPECT`; held until next accepted start.
- `table_out`  output  4  measured truth table of last sweep, bit {a,b}.

## Operation

- State register: IDLE, DRIVE, SAMPLE, DONE. 2-bit vector index `idx`, 8-bit settle counter `cnt`.
- IDLE: `x_out`=`y_out`=0. `start`=1 → `idx`←0, `cnt`←0, `pass`←0, `table_out`←0, go DRIVE.
- DRIVE: `x_out`=`idx[1]`, `y_out`=`idx[0]` (registered, stable the whole vector). `cnt` increments; when `cnt`==SETTLE-1 go SAMPLE.
- SAMPLE: inputs still driven from `idx`. `table_out[idx]`←`s_in`. If `idx`==3: `pass`←({`s_in`,`table_out[2:0]`}==EXPECT), go DONE. Else `idx`←`idx`+1, `cnt`←0, go DRIVE.
- DONE: `done`=1 for this single cycle, `x_out`=`y_out`=0, unconditionally go IDLE. `start` in DONE is ignored.
- `busy` = state ∈ {DRIVE, SAMPLE}; `done` = state==DONE; both decoded from the state register (glitch-free, no input paths).
- `start` during DRIVE/SAMPLE is ignored (see Configuration).
- `idx` does not wrap; sweep ends at `idx`==3.

## Timing

- Reset: state IDLE, `idx`=0, `cnt`=0; `x_out`, `y_out`, `busy`, `done`, `pass`=0, `table_out`=4'b0000. Reset wins over every other event, including mid-sweep; sweep aborted, no `done` pulse.
- `start` accepted at edge N → `busy`=1 and vector 00 driven from cycle N+1.
- Each vector occupies SETTLE+1 cycles (SETTLE DRIVE + 1 SAMPLE); `s_in` sampled SETTLE cycles after the vector is first applied.
- DONE entered at edge N+4·(SETTLE+1); `done` high for exactly that one cycle; `pass`/`table_out` final from the same edge. SETTLE=1 → `done` 8 cycles after accept.
- Earliest next accept: the cycle after `done` (back-to-back sweeps 4·(SETTLE+1)+2 cycles apart).

## Configuration

- `F5_SWEEP_RESTART_EN` defined: `start`=1 during DRIVE or SAMPLE aborts the current sweep and restarts exactly as an IDLE accept (`idx`, `cnt`, `pass`, `table_out` cleared, vector 00 next cycle); no `done` for the aborted sweep.
- Not defined: `start` outside IDLE has no effect; RTL contains no restart path.

## Test plan

- Reset held 2 cycles → all outputs 0, `table_out`=0000; `done` stays 0 with `start`=0 for 10 cycles.
- SETTLE=1, `s_in` from real `f5_nand`, 1-cycle `start` → `x_out,y_out` = 00,01,10,11 each 2 cycles; `done` 8 cycles after accept; `table_out`=1011, `pass`=1.
- `s_in` forced 0 → `table_out`=0000, `pass`=0; `s_in` forced 1 → 1111, `pass`=0.
- SETTLE=3 → each vector 4 cycles, `done` 16 cycles after accept; glitch on `s_in` during first 2 DRIVE cycles of a vector not captured.
- `reset` asserted at vector 10 → IDLE next edge, outputs 0, no `done`; `start` on following cycle runs a full sweep, `pass`=1.
- `start` re-pulsed at cycle 5 of a sweep: macro off → `done` still at cycle 8; `F5_SWEEP_RESTART_EN` on → vector 00 at cycle 6, `done` 8 cycles after the re-pulse.
